// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential unsigned WIDTH x WIDTH multiplier (add/shift method).
// Every addition is performed by an external alu driven through the alu_* ports;
// this block only holds the accumulator, multiplier shift register, carry and FSM.
// Optional build macro: MUL_ZERO_SKIP_EN -- skip the ADD step for multiplier
// bits that are 0, shortening latency to WIDTH + popcount(op_b) cycles.
module alu_mul_seq #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [1:0]         alu_op,
   output logic               alu_arit,
   input  logic [WIDTH-1:0]   alu_r,
   input  logic               alu_carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [WIDTH-1:0] m;     // captured multiplicand
   logic [WIDTH-1:0] hi;    // accumulator / product high half
   logic [WIDTH-1:0] q;     // multiplier, becomes product low half
   logic             c;     // carry out of the last add, shifted into hi
   logic [CW-1:0]    cnt;   // number of completed shift steps
   logic             last;

   assign last = (cnt == CW'(WIDTH - 1));

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and the update order inside the block is irrelevant.
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default assigned first so no path through the case leaves
      // state_n unassigned, which would otherwise infer a latch.
      state_n = state;
      unique case (state)
         IDLE: begin
            if (start) begin
`ifdef MUL_ZERO_SKIP_EN
               state_n = op_b[0] ? ADD : SHIFT;
`else
               state_n = ADD;
`endif
            end
         end
         ADD:   state_n = SHIFT;
         SHIFT: begin
            if (last) begin
               state_n = DONE;
            end else begin
`ifdef MUL_ZERO_SKIP_EN
               // q[1] is the multiplier bit that lands in q[0] after this shift.
               state_n = q[1] ? ADD : SHIFT;
`else
               state_n = ADD;
`endif
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath: operand capture, conditional accumulate, combined right shift.
   always_ff @(posedge clk) begin
      if (!reset) begin
         m       <= '0;
         hi      <= '0;
         q       <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  m   <= op_a;
                  q   <= op_b;
                  hi  <= '0;
                  c   <= 1'b0;
                  cnt <= '0;
               end
            end
            ADD: begin
               if (q[0]) begin
                  hi <= alu_r;
                  c  <= alu_carry;
               end else begin
                  c  <= 1'b0;
               end
            end
            SHIFT: begin
               hi <= {c, hi[WIDTH-1:1]};
               q  <= {hi[0], q[WIDTH-1:1]};
               c  <= 1'b0;
               if (last) begin
                  // Load the post-shift {hi,q} on the edge that enters DONE.
                  product <= {c, hi, q[WIDTH-1:1]};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Moore outputs decoded from the state; the alu always sees hi + m.
   always_comb begin
      busy     = (state == ADD) || (state == SHIFT);
      done     = (state == DONE);
      alu_arit = (state == ADD);
      alu_a    = hi;
      alu_b    = m;
      alu_op   = 2'b00;
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq. Plays the parent role by
// modelling the external alu, and compares against plain a*b arithmetic.
module tb_alu_mul_seq;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   op_a = '0;
   logic [W-1:0]   op_b = '0;
   logic           busy, done;
   logic [2*W-1:0] product;
   logic [W-1:0]   alu_a, alu_b, alu_r;
   logic [1:0]     alu_op;
   logic           alu_arit, alu_carry;

   int n_pass  = 0;
   int n_total = 0;
   logic [2*W-1:0] last_product = '0;

   alu_mul_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .product(product),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_arit(alu_arit),
      .alu_r(alu_r), .alu_carry(alu_carry)
   );

   always #5 clk = ~clk;

   // External alu: {arit=1, op=00} is A+B with carry-out; other selects give 0.
   always_comb begin
      if (alu_arit && alu_op == 2'b00) {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      else                             {alu_carry, alu_r} = '0;
   end

   function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
      return W + $countones(b);
`else
      return 2 * W;
`endif
   endfunction

   function automatic int exp_adds(input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
      return $countones(b);
`else
      return W;
`endif
   endfunction

   // Called at a negedge with the DUT in IDLE; start is accepted at the next posedge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the first negedge after the accepting edge. Watches until done,
   // checks latency, busy/add counts and the product, then one more cycle.
   // pulse_at >= 0 re-pulses start (1x1) at that cycle; hold_next asserts start
   // with (na,nb) while done is high so the caller's launch follows immediately.
   task automatic finish_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int pulse_at, input bit hold_next,
                            input logic [W-1:0] na, input logic [W-1:0] nb);
      logic [2*W-1:0] exp_p;
      int j, busy_cnt, arit_cnt;
      bit seen, stable_ok;
      exp_p = (2*W)'(a) * (2*W)'(b);
      j = 0; busy_cnt = 0; arit_cnt = 0; seen = 0; stable_ok = 1;
      while (!seen && j < 64) begin
         if (done) begin
            seen = 1;
         end else begin
            if (busy) busy_cnt++;
            if (alu_arit) begin
               arit_cnt++;
               if (alu_b !== a) stable_ok = 0;
            end
            if (product !== last_product) stable_ok = 0;
            if (pulse_at >= 0) begin
               if (j == pulse_at) begin op_a = 1; op_b = 1; start = 1'b1; end
               else start = 1'b0;
            end
            @(negedge clk);
            j++;
         end
      end
      start = 1'b0;
      n_total++;
      if (!seen) begin
         $display("FAIL %s timeout: done not seen within %0d cycles", name, j);
         return;
      end else n_pass++;
      n_total++;
      if (j != exp_latency(b)) $display("FAIL %s latency: got %0d expected %0d", name, j, exp_latency(b));
      else n_pass++;
      n_total++;
      if (busy_cnt != exp_latency(b)) $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_latency(b));
      else n_pass++;
      n_total++;
      if (arit_cnt != exp_adds(b)) $display("FAIL %s add_cycles: got %0d expected %0d", name, arit_cnt, exp_adds(b));
      else n_pass++;
      n_total++;
      if (!stable_ok) $display("FAIL %s held_values: product or alu_b changed during operation (product=%h prev=%h)", name, product, last_product);
      else n_pass++;
      n_total++;
      if (product !== exp_p) $display("FAIL %s product: got %h expected %h", name, product, exp_p);
      else n_pass++;
      last_product = exp_p;
      if (hold_next) begin op_a = na; op_b = nb; start = 1'b1; end
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p)
         $display("FAIL %s after_done: done=%b busy=%b product=%h expected 0/0/%h", name, done, busy, product, exp_p);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || alu_arit !== 1'b0 || alu_op !== 2'b00)
         $display("FAIL reset_state: busy=%b done=%b product=%h arit=%b op=%b expected 0/0/00/0/00",
                  busy, done, product, alu_arit, alu_op);
      else n_pass++;
      last_product = '0;
   endtask

   task automatic test_directed();
      launch(4'd3, 4'd5);   finish_op("mul_3x5",   4'd3,  4'd5,  -1, 0, '0, '0);
      launch(4'd15, 4'd15); finish_op("mul_15x15", 4'd15, 4'd15, -1, 0, '0, '0);
      launch(4'd9, 4'd0);   finish_op("mul_9x0",   4'd9,  4'd0,  -1, 0, '0, '0);
      launch(4'd0, 4'd11);  finish_op("mul_0x11",  4'd0,  4'd11, -1, 0, '0, '0);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         launch(a, b);
         finish_op($sformatf("rand%0d_%0dx%0d", i, a, b), a, b, -1, 0, '0, '0);
      end
   endtask

   task automatic test_ignore_start();
      launch(4'd15, 4'd15);
      finish_op("busy_start", 4'd15, 4'd15, 2, 0, '0, '0);
      launch(4'd1, 4'd1);
      finish_op("mul_1x1", 4'd1, 4'd1, -1, 0, '0, '0);
   endtask

   task automatic test_back_to_back();
      launch(4'd13, 4'd6);
      finish_op("b2b_first", 4'd13, 4'd6, -1, 1, 4'd11, 4'd14);
      launch(4'd11, 4'd14);
      finish_op("b2b_second", 4'd11, 4'd14, -1, 0, '0, '0);
   endtask

   task automatic test_reset_mid();
      int dones;
      launch(4'd7, 4'd6);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || alu_arit !== 1'b0)
         $display("FAIL mid_reset_state: busy=%b done=%b product=%h arit=%b expected 0/0/00/0",
                  busy, done, product, alu_arit);
      else n_pass++;
      last_product = '0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      n_total++;
      if (dones != 0) $display("FAIL mid_reset_quiet: got %0d busy/done cycles expected 0", dones);
      else n_pass++;
      launch(4'd7, 4'd6);
      finish_op("mul_7x6_after_reset", 4'd7, 4'd6, -1, 0, '0, '0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
